// File: rtl/gpio_cfg_sequencer_if.sv
// Bundles the control, table and decoder-bus signals of gpio_cfg_sequencer.
// The master modport is the sequencer side; the slave modport is the surrounding system.
interface gpio_cfg_sequencer_if #(
  parameter int AddrWidth = 16,
  parameter int BusWidth  = 32
);
  logic                          start;
  logic [7:0]                    tbl_index;
  logic [AddrWidth+BusWidth-1:0] tbl_entry;
  logic                          host_req;
  logic                          host_write;
  logic [AddrWidth-1:0]          host_addr;
  logic [BusWidth-1:0]           host_wdata;
  logic                          host_grant;
  logic                          chip_sel;
  logic                          write_reg;
  logic                          read_reg;
  logic [AddrWidth-3:0]          busaddress;
  logic [BusWidth-1:0]           busdata_out;
  logic [BusWidth-1:0]           busdata_in;
  logic                          busy;
  logic                          done;
  logic                          err;
  logic [7:0]                    skip_cnt;

  modport master (
    input  start,
    output tbl_index,
    input  tbl_entry,
    input  host_req,
    input  host_write,
    input  host_addr,
    input  host_wdata,
    output host_grant,
    output chip_sel,
    output write_reg,
    output read_reg,
    output busaddress,
    output busdata_out,
    input  busdata_in,
    output busy,
    output done,
    output err,
    output skip_cnt
  );

  modport slave (
    output start,
    input  tbl_index,
    output tbl_entry,
    output host_req,
    output host_write,
    output host_addr,
    output host_wdata,
    input  host_grant,
    input  chip_sel,
    input  write_reg,
    input  read_reg,
    input  busaddress,
    input  busdata_out,
    output busdata_in,
    input  busy,
    input  done,
    input  err,
    input  skip_cnt
  );
endinterface

// File: rtl/gpio_cfg_sequencer.sv
// Walks a {addr,data} ROM table and issues decoder write cycles; the host may use the bus when idle.
// Optional macro GPIO_CFG_READBACK_EN adds a read-back-and-compare phase after every write.
module gpio_cfg_sequencer #(
  parameter int AddrWidth  = 16,
  parameter int BusWidth   = 32,
  parameter int NumEntries = 16,
  parameter int HoldCycles = 2
) (
  input  logic                  reg_clk,
  input  logic                  reset_reg_N,
  gpio_cfg_sequencer_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef GPIO_CFG_READBACK_EN
  localparam logic [2:0] S_RDBK  = 3'd5;
  localparam logic [2:0] S_CHECK = 3'd6;
`endif

  // Index is one bit wider than the port so that NumEntries = 256 is still reachable.
  localparam int              IdxW    = 9;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumEntries);
  localparam int              CntW    = 4;
  localparam logic [CntW-1:0] WrLast  = CntW'(HoldCycles - 1);
`ifdef GPIO_CFG_READBACK_EN
  localparam logic [CntW-1:0] RdLast  = CntW'(HoldCycles + 2);
`endif

  localparam logic [AddrWidth-1:0] EndMarker = AddrWidth'(16'hFFFF);
  localparam logic [AddrWidth-1:0] WinLo     = AddrWidth'(16'h1100);
  localparam logic [AddrWidth-1:0] WinHi     = AddrWidth'(16'h13FF);

  logic [2:0]           r_state;
  logic [IdxW-1:0]      r_index;
  logic [CntW-1:0]      r_hold;
  logic [AddrWidth-3:0] r_waddr;
  logic [BusWidth-1:0]  r_data;
  logic                 r_err;
  logic [7:0]           r_skip;
`ifdef GPIO_CFG_READBACK_EN
  logic [BusWidth-1:0]  r_rdata;
`endif

  logic [AddrWidth-1:0] w_entry_addr;
  logic [BusWidth-1:0]  w_entry_data;
  logic                 w_entry_ok;
  logic                 w_bus_free;
  logic                 w_grant;
  logic                 w_chip_sel;
  logic                 w_write;
  logic                 w_read;
  logic [AddrWidth-3:0] w_baddr;
  logic [BusWidth-1:0]  w_bdata;
  logic                 w_unused_bits;

  assign w_entry_addr = bus.tbl_entry[AddrWidth+BusWidth-1:BusWidth];
  assign w_entry_data = bus.tbl_entry[BusWidth-1:0];
  assign w_entry_ok   = (w_entry_addr >= WinLo) && (w_entry_addr <= WinHi) &&
                        (w_entry_addr[1:0] == 2'b00);
  assign w_bus_free   = (r_state == S_IDLE) || (r_state == S_DONE);

  // A start pulse beats a simultaneous host request; reset also blocks the grant.
  assign w_grant = reset_reg_N & w_bus_free & bus.host_req & ~bus.start;

`ifdef GPIO_CFG_READBACK_EN
  assign w_unused_bits = ^bus.host_addr[1:0];
`else
  assign w_unused_bits = ^{bus.host_addr[1:0], bus.busdata_in};
`endif

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_hold  <= '0;
      r_waddr <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_skip  <= '0;
`ifdef GPIO_CFG_READBACK_EN
      r_rdata <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_FETCH;
            r_index <= '0;
            r_err   <= 1'b0;
            r_skip  <= '0;
          end
        end
        S_FETCH: begin
          if ((r_index == LastIdx) || (w_entry_addr == EndMarker)) begin
            r_state <= S_DONE;
          end else if (!w_entry_ok) begin
            if (r_skip != 8'hFF) begin
              r_skip <= r_skip + 8'd1;
            end
            r_err   <= 1'b1;
            r_index <= r_index + 1'b1;
          end else begin
            r_waddr <= w_entry_addr[AddrWidth-1:2];
            r_data  <= w_entry_data;
            r_hold  <= '0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_hold == WrLast) begin
            r_hold  <= '0;
`ifdef GPIO_CFG_READBACK_EN
            r_state <= S_RDBK;
`else
            r_state <= S_GAP;
`endif
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
`ifdef GPIO_CFG_READBACK_EN
        S_RDBK: begin
          if (r_hold == RdLast) begin
            r_rdata <= bus.busdata_in;
            r_hold  <= '0;
            r_state <= S_CHECK;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_CHECK: begin
          if (r_rdata != r_data) begin
            r_err <= 1'b1;
          end
          r_state <= S_GAP;
        end
`endif
        S_GAP: begin
          r_index <= r_index + 1'b1;
          r_state <= S_FETCH;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus mux: the sequencer drives it in WRITE/RDBK, a granted host drives it otherwise.
  always_comb begin
    w_chip_sel = 1'b0;
    w_write    = 1'b0;
    w_read     = 1'b0;
    w_baddr    = '0;
    w_bdata    = '0;
    case (r_state)
      S_WRITE: begin
        w_chip_sel = 1'b1;
        w_write    = 1'b1;
        w_baddr    = r_waddr;
        w_bdata    = r_data;
      end
`ifdef GPIO_CFG_READBACK_EN
      S_RDBK: begin
        w_chip_sel = 1'b1;
        w_read     = 1'b1;
        w_baddr    = r_waddr;
        w_bdata    = r_data;
      end
`endif
      default: begin
        if (w_grant) begin
          w_chip_sel = 1'b1;
          w_write    = bus.host_write;
          w_read     = ~bus.host_write;
          w_baddr    = bus.host_addr[AddrWidth-1:2];
          w_bdata    = bus.host_wdata;
        end
      end
    endcase
  end

  assign bus.tbl_index   = r_index[7:0];
  assign bus.host_grant  = w_grant;
  assign bus.chip_sel    = w_chip_sel;
  assign bus.write_reg   = w_write;
  assign bus.read_reg    = w_read;
  assign bus.busaddress  = w_baddr;
  assign bus.busdata_out = w_bdata;
  assign bus.busy        = ~w_bus_free;
  assign bus.done        = (r_state == S_DONE);
  assign bus.err         = r_err;
  assign bus.skip_cnt    = r_skip;

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Scoreboard bench for gpio_cfg_sequencer: expected table writes are queued at stimulus time
// and popped by a bus monitor as each sequencer write strobe completes.
module tb_gpio_cfg_sequencer;
  localparam int AW = 16;
  localparam int BW = 32;
  localparam int NE = 16;
  localparam int HC = 2;

  typedef struct {
    logic [AW-3:0] addr;
    logic [BW-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpio_cfg_sequencer_if #(.AddrWidth(AW), .BusWidth(BW)) bus_if ();

  gpio_cfg_sequencer #(
    .AddrWidth (AW),
    .BusWidth  (BW),
    .NumEntries(NE),
    .HoldCycles(HC)
  ) dut (
    .reg_clk    (clk),
    .reset_reg_N(rst_n),
    .bus        (bus_if)
  );

  logic [AW+BW-1:0] tbl_mem [0:NE-1];
  logic [BW-1:0]    dec_mem [0:1023];
  logic             force_zero = 1'b0;

  assign bus_if.tbl_entry  = (bus_if.tbl_index < 8'(NE)) ? tbl_mem[bus_if.tbl_index[3:0]]
                                                         : {16'hFFFF, 32'h0};
  assign bus_if.busdata_in = force_zero ? '0 : dec_mem[bus_if.busaddress[9:0]];

  // Simple register-file decoder so read-back sees what was written.
  always @(posedge clk) begin
    if (bus_if.chip_sel && bus_if.write_reg) dec_mem[bus_if.busaddress[9:0]] <= bus_if.busdata_out;
  end

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Monitor: captures each sequencer write strobe and checks it against the scoreboard.
  initial begin
    bit            in_pulse;
    bit            stable;
    int            width;
    logic [AW-3:0] m_addr;
    logic [BW-1:0] m_data;
    wr_t           e;
    in_pulse = 0;
    stable   = 1;
    width    = 0;
    m_addr   = '0;
    m_data   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pulse = 0;
      end else if (bus_if.busy && bus_if.write_reg) begin
        if (!in_pulse) begin
          in_pulse = 1;
          stable   = 1;
          width    = 1;
          m_addr   = bus_if.busaddress;
          m_data   = bus_if.busdata_out;
        end else begin
          width++;
          if (bus_if.busaddress !== m_addr || bus_if.busdata_out !== m_data) stable = 0;
        end
      end else if (in_pulse) begin
        in_pulse = 0;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", m_addr, m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_addr !== e.addr) begin
            n_fail++;
            $display("FAIL write_addr: got %h, expected %h", m_addr, e.addr);
          end
          n_tests++;
          if (m_data !== e.data) begin
            n_fail++;
            $display("FAIL write_data: got %h, expected %h", m_data, e.data);
          end
          n_tests++;
          if (width != HC) begin
            n_fail++;
            $display("FAIL write_width: got %0d, expected %0d", width, HC);
          end
          n_tests++;
          if (!stable) begin
            n_fail++;
            $display("FAIL write_stable: bus changed during strobe at addr %h", e.addr);
          end
          $display("[TB] write addr=%h data=%h width=%0d", m_addr, m_data, width);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_table();
    for (int i = 0; i < NE; i++) tbl_mem[i] = {16'hFFFF, 32'h0};
  endtask

  task automatic add_entry(input int idx, input logic [AW-1:0] a, input logic [BW-1:0] d,
                           input bit expect_write);
    wr_t w;
    tbl_mem[idx] = {a, d};
    if (expect_write) begin
      w.addr = a[AW-1:2];
      w.data = d;
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus_if.done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [68:0] outs;
    bus_if.host_req = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    outs = {bus_if.tbl_index, bus_if.host_grant, bus_if.chip_sel, bus_if.write_reg,
            bus_if.read_reg, bus_if.busaddress, bus_if.busdata_out, bus_if.busy,
            bus_if.done, bus_if.err, bus_if.skip_cnt};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    bus_if.host_req = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({bus_if.busy, bus_if.done, bus_if.tbl_index} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b idx=%0d, expected 0 0 0",
               bus_if.busy, bus_if.done, bus_if.tbl_index);
    end
    $display("[TB] test_reset complete");
  endtask

  task automatic test_single();
    bit ok;
    clear_table();
    add_entry(0, 16'h1100, 32'h00FF_FFFF, 1);
    pulse_start();
    @(negedge clk);
    n_tests++;
    if (bus_if.write_reg !== 1'b0 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_fetch: write_reg=%b busy=%b, expected 0 1", bus_if.write_reg, bus_if.busy);
    end
    @(negedge clk);
    n_tests++;
    if (bus_if.write_reg !== 1'b1 || bus_if.chip_sel !== 1'b1 || bus_if.read_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: cs=%b wr=%b rd=%b, expected 1 1 0",
               bus_if.chip_sel, bus_if.write_reg, bus_if.read_reg);
    end
    n_tests++;
    if (bus_if.busaddress !== 14'h0440) begin
      n_fail++;
      $display("FAIL single_addr: got %h, expected 0440", bus_if.busaddress);
    end
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_done: done=%b, expected 1 within bound", bus_if.done);
    end
    n_tests++;
    if (bus_if.err !== 1'b0 || bus_if.skip_cnt !== 8'd0 || bus_if.tbl_index !== 8'd1 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_status: err=%b skip=%0d idx=%0d busy=%b, expected 0 0 1 0",
               bus_if.err, bus_if.skip_cnt, bus_if.tbl_index, bus_if.busy);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_pending: %0d writes missing, expected 0", exp_q.size());
    end
    $display("[TB] test_single complete");
  endtask

  task automatic test_skip();
    bit ok;
    clear_table();
    add_entry(0, 16'h1000, 32'h1, 0);
    add_entry(1, 16'h1104, 32'h5, 1);
    pulse_start();
    wait_done(ok);
    n_tests++;
    if (!ok || bus_if.skip_cnt !== 8'd1 || bus_if.err !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_status: done=%b skip=%0d err=%b, expected 1 1 1",
               bus_if.done, bus_if.skip_cnt, bus_if.err);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL skip_pending: %0d writes missing, expected 0", exp_q.size());
    end
    $display("[TB] test_skip complete");
  endtask

  task automatic test_window_edges();
    bit ok;
    clear_table();
    add_entry(0, 16'h1102, 32'h11, 0);
    add_entry(1, 16'h13FC, 32'hA5A5_0001, 1);
    add_entry(2, 16'h13FF, 32'h22, 0);
    add_entry(3, 16'h1400, 32'h33, 0);
    add_entry(4, 16'h10FC, 32'h44, 0);
    add_entry(5, 16'h1100, 32'h5A5A_0002, 1);
    pulse_start();
    wait_done(ok);
    n_tests++;
    if (!ok || bus_if.skip_cnt !== 8'd4 || bus_if.err !== 1'b1 || bus_if.tbl_index !== 8'd6) begin
      n_fail++;
      $display("FAIL window_status: done=%b skip=%0d err=%b idx=%0d, expected 1 4 1 6",
               bus_if.done, bus_if.skip_cnt, bus_if.err, bus_if.tbl_index);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL window_pending: %0d writes missing, expected 0", exp_q.size());
    end
    $display("[TB] test_window_edges complete");
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_table();
    add_entry(0, 16'h1200, 32'hCAFE_0000, 1);
    pulse_start();
    @(negedge clk);
    n_tests++;
    if (bus_if.done !== 1'b0 || bus_if.err !== 1'b0 || bus_if.skip_cnt !== 8'd0 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: done=%b err=%b skip=%0d busy=%b, expected 0 0 0 1",
               bus_if.done, bus_if.err, bus_if.skip_cnt, bus_if.busy);
    end
    wait_done(ok);
    n_tests++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_done: done=%b pending=%0d, expected 1 0", bus_if.done, exp_q.size());
    end
    $display("[TB] test_back_to_back complete");
  endtask

  task automatic test_host();
    bit ok;
    clear_table();
    for (int i = 0; i < 3; i++) add_entry(i, 16'(16'h1180 + 4 * i), 32'(32'h100 + i), 1);
    pulse_start();
    bus_if.host_req   = 1'b1;
    bus_if.host_write = 1'b1;
    bus_if.host_addr  = 16'h1300;
    bus_if.host_wdata = 32'hDEAD_BEEF;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus_if.done) begin
        ok = 1;
        break;
      end
      n_tests++;
      if (bus_if.host_grant !== 1'b0) begin
        n_fail++;
        $display("FAIL host_blocked: grant=%b during sequence, expected 0", bus_if.host_grant);
      end
    end
    n_tests++;
    if (!ok || bus_if.host_grant !== 1'b1 || bus_if.write_reg !== 1'b1 || bus_if.chip_sel !== 1'b1 ||
        bus_if.read_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL host_write: done=%b grant=%b cs=%b wr=%b rd=%b, expected 1 1 1 1 0", bus_if.done,
               bus_if.host_grant, bus_if.chip_sel, bus_if.write_reg, bus_if.read_reg);
    end
    n_tests++;
    if (bus_if.busaddress !== 14'h04C0 || bus_if.busdata_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL host_bus: addr=%h data=%h, expected 04c0 deadbeef", bus_if.busaddress, bus_if.busdata_out);
    end
    @(posedge clk);
    #1 bus_if.host_write = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus_if.read_reg !== 1'b1 || bus_if.write_reg !== 1'b0 || bus_if.chip_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL host_read: cs=%b wr=%b rd=%b, expected 1 0 1",
               bus_if.chip_sel, bus_if.write_reg, bus_if.read_reg);
    end
    for (int i = 0; i < 3; i++) begin
      wr_t w;
      w.addr = 14'(((16'h1180 + 4 * i) >> 2));
      w.data = 32'(32'h100 + i);
      exp_q.push_back(w);
    end
    @(posedge clk);
    #1 bus_if.start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_if.host_grant !== 1'b0 || bus_if.chip_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL start_wins: grant=%b cs=%b, expected 0 0", bus_if.host_grant, bus_if.chip_sel);
    end
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus_if.busy !== 1'b1 || bus_if.host_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL start_wins_state: busy=%b grant=%b, expected 1 0", bus_if.busy, bus_if.host_grant);
    end
    bus_if.host_req = 1'b0;
    wait_done(ok);
    n_tests++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL start_wins_done: done=%b pending=%0d, expected 1 0", bus_if.done, exp_q.size());
    end
    $display("[TB] test_host complete");
  endtask

  task automatic test_full_table();
    bit ok;
    clear_table();
    for (int i = 0; i < NE; i++) add_entry(i, 16'(16'h1100 + 4 * i), $urandom, 1);
    pulse_start();
    repeat (7) @(negedge clk);
    pulse_start();
    wait_done(ok);
    n_tests++;
    if (!ok || bus_if.tbl_index !== 8'(NE) || bus_if.skip_cnt !== 8'd0 || bus_if.err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_status: done=%b idx=%0d skip=%0d err=%b, expected 1 %0d 0 0",
               bus_if.done, bus_if.tbl_index, bus_if.skip_cnt, bus_if.err, NE);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_pending: %0d writes missing, expected 0", exp_q.size());
    end
    $display("[TB] test_full_table complete");
  endtask

  task automatic test_reset_mid();
    bit          ok;
    bit          hit;
    logic [68:0] outs;
    clear_table();
    for (int i = 0; i < 3; i++) add_entry(i, 16'(16'h1240 + 4 * i), 32'(32'h7700 + i), 1);
    pulse_start();
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.busy && bus_if.write_reg && bus_if.tbl_index == 8'd1) begin
        hit = 1;
        break;
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midreset_reach: second write not seen, idx=%0d", bus_if.tbl_index);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus_if.tbl_index, bus_if.host_grant, bus_if.chip_sel, bus_if.write_reg,
            bus_if.read_reg, bus_if.busaddress, bus_if.busdata_out, bus_if.busy,
            bus_if.done, bus_if.err, bus_if.skip_cnt};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h, expected 0", outs);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      wr_t w;
      w.addr = 14'(((16'h1240 + 4 * i) >> 2));
      w.data = 32'(32'h7700 + i);
      exp_q.push_back(w);
    end
    pulse_start();
    wait_done(ok);
    n_tests++;
    if (!ok || exp_q.size() != 0 || bus_if.tbl_index !== 8'd3) begin
      n_fail++;
      $display("FAIL midreset_replay: done=%b pending=%0d idx=%0d, expected 1 0 3",
               bus_if.done, exp_q.size(), bus_if.tbl_index);
    end
    $display("[TB] test_reset_mid complete");
  endtask

`ifdef GPIO_CFG_READBACK_EN
  task automatic test_readback();
    bit ok;
    clear_table();
    add_entry(0, 16'h1100, 32'h1, 1);
    force_zero = 1'b1;
    pulse_start();
    wait_done(ok);
    n_tests++;
    if (!ok || bus_if.err !== 1'b1 || bus_if.skip_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL readback_err: done=%b err=%b skip=%0d, expected 1 1 0",
               bus_if.done, bus_if.err, bus_if.skip_cnt);
    end
    force_zero = 1'b0;
    $display("[TB] test_readback complete");
  endtask
`endif

  initial begin
    bus_if.start      = 1'b0;
    bus_if.host_req   = 1'b0;
    bus_if.host_write = 1'b0;
    bus_if.host_addr  = '0;
    bus_if.host_wdata = '0;
    for (int i = 0; i < 1024; i++) dec_mem[i] = '0;
    clear_table();
    test_reset();
    test_single();
    test_skip();
    test_window_edges();
    test_back_to_back();
    test_host();
    test_full_table();
    test_reset_mid();
`ifdef GPIO_CFG_READBACK_EN
    test_readback();
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_cfg_sequencer.md
GPIO_CFG_SEQUENCER -- requirements
Module: gpio_cfg_sequencer

Interface
REQ-001 SHALL have parameter AddrWidth, default 16, bus byte-address width.
REQ-002 SHALL have parameter BusWidth, default 32, bus data width.
REQ-003 SHALL have parameter NumEntries, default 16, configuration table depth (2..256).
REQ-004 SHALL have parameter HoldCycles, default 2, write/read strobe width in clocks (1..7).
REQ-005 SHALL have ports, in order:
  reg_clk  in  1  sole clock, all logic on its rising edge
  reset_reg_N  in  1  asynchronous active-low reset
  start  in  1  single-cycle pulse, begin table sequence
  tbl_index  out  8  table entry index
  tbl_entry  in  AddrWidth+BusWidth  {addr, data}; combinational ROM, valid the same cycle tbl_index is presented
  host_req  in  1  host requests one bus cycle
  host_write  in  1  1 = write, 0 = read
  host_addr  in  AddrWidth  host byte address
  host_wdata  in  BusWidth  host write data
  host_grant  out  1  host owns the bus
  chip_sel  out  1  decoder chip select
  write_reg  out  1  decoder write strobe
  read_reg  out  1  decoder read strobe
  busaddress  out  AddrWidth-2  word address (byte address bits [AddrWidth-1:2])
  busdata_out  out  BusWidth  write data to decoder
  busdata_in  in  BusWidth  read data from decoder
  busy  out  1  sequence in progress
  done  out  1  sequence completed; sticky until next start
  err  out  1  sticky error flag
  skip_cnt  out  8  count of rejected entries

Function
REQ-006 SHALL implement states IDLE, FETCH, WRITE, GAP and DONE, plus RDBK and CHECK when GPIO_CFG_READBACK_EN is defined.
REQ-007 SHALL transition IDLE/DONE->FETCH on start, clearing tbl_index, done, err and skip_cnt; start in FETCH/WRITE/GAP/RDBK/CHECK SHALL be ignored.
REQ-008 In FETCH, entry address 0xFFFF or tbl_index == NumEntries SHALL transition to DONE (end marker).
REQ-009 In FETCH, an entry address outside 0x1100..0x13FF or not word-aligned SHALL be skipped: skip_cnt saturating +1, err set, tbl_index +1, stay in FETCH.
REQ-010 A valid entry SHALL be registered (address, data) and transition to WRITE on the next clock; the first write_reg SHALL assert 2 clocks after start.
REQ-011 WRITE SHALL hold chip_sel=1, write_reg=1 for exactly HoldCycles clocks with busaddress/busdata_out stable, then go to GAP (RDBK when readback is enabled).
REQ-012 GAP SHALL deassert all strobes for exactly 1 clock, increment tbl_index, then return to FETCH.
REQ-013 busy SHALL be 1 in every state except IDLE and DONE; done SHALL be 1 only in DONE.
REQ-014 host_grant SHALL equal host_req while the state is IDLE or DONE, and SHALL be 0 otherwise.
REQ-015 A granted host cycle SHALL drive chip_sel with write_reg (host_write=1) or read_reg (host_write=0), plus host_addr[AddrWidth-1:2] and host_wdata, combinationally.
REQ-016 A start arriving in the same cycle as host_req in IDLE/DONE SHALL win: host_grant=0 that cycle and the state goes to FETCH.
REQ-017 tbl_index SHALL never exceed NumEntries; skip_cnt SHALL saturate at 255.
REQ-018 When the sequencer owns the bus, read_reg SHALL be 0 except in RDBK.

Reset
REQ-019 Asserting reset_reg_N=0 at any time, including mid-sequence, SHALL immediately force state IDLE and all outputs to 0 (tbl_index=0, strobes=0, busaddress=0, busdata_out=0, busy=0, done=0, err=0, skip_cnt=0, host_grant=0).
REQ-020 After reset release, the block SHALL stay in IDLE until start.

Configuration
REQ-021 With GPIO_CFG_READBACK_EN defined:
  - RDBK SHALL assert chip_sel and read_reg for HoldCycles+3 clocks at the same address.
  - CHECK SHALL compare busdata_in, sampled on the last RDBK clock, with the written data.
  - A mismatch SHALL set err; CHECK then goes to GAP.
REQ-022 Without GPIO_CFG_READBACK_EN, RDBK and CHECK SHALL NOT exist, read_reg SHALL only be driven by host cycles, and WRITE SHALL go directly to GAP.

Verification
REQ-023 Table {0x1100,0x00FFFFFF},{0xFFFF,x}, start pulse -> first write_reg asserted 2 clocks later; write_reg high 2 clocks; busaddress=0x0440; done=1 after GAP; err=0.
REQ-024 Table {0x1000,0x1},{0x1104,0x5} -> skip_cnt=1, err=1, exactly one write, to 0x1104 with data 0x5.
REQ-025 host_req=1 with host_write=1, host_addr=0x1300, during a sequence -> host_grant=0 until done=1, then host_grant=1 and write_reg=1 to word address 0x04C0.
REQ-026 Full table of 16 valid entries, no end marker -> 16 writes, tbl_index stops at 16, done=1.
REQ-027 reset_reg_N pulsed low during the second WRITE -> all outputs 0 in the same cycle; the next start replays from entry 0.
REQ-028 GPIO_CFG_READBACK_EN defined, busdata_in forced to 0x0 after a write of 0x1 -> err=1, sequence still completes with done=1.
